// File: rtl/atomic_counter_reader.sv
// atomic_counter_reader: two-phase tear-free 64-bit snapshot reader with timeout (optional ATOMIC_READER_DELTA_EN adds delta/first_n)
module atomic_counter_reader #(
  parameter int DATA_W = 32,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                timeout_err,
  output logic [2*DATA_W-1:0] value,
  output logic                req,
  output logic                atomic,
  input  logic                ack,
  input  logic [DATA_W-1:0]   count
`ifdef ATOMIC_READER_DELTA_EN
  ,
  output logic [2*DATA_W-1:0] delta,
  output logic                first_n
`endif
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, REQ_LO, WAIT_LO, REQ_HI, WAIT_HI} state_t;
  state_t state;
  logic [DATA_W-1:0] lo;
  logic [TW-1:0] tcnt;
`ifdef ATOMIC_READER_DELTA_EN
  logic have_one;
`endif
  assign busy = state != IDLE;
  assign req = state == REQ_LO || state == REQ_HI;
  assign atomic = state == REQ_LO;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      lo <= '0;
      tcnt <= '0;
      value <= '0;
      done <= 1'b0;
      timeout_err <= 1'b0;
`ifdef ATOMIC_READER_DELTA_EN
      delta <= '0;
      first_n <= 1'b0;
      have_one <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: if (start) state <= REQ_LO;
        REQ_LO: begin
          state <= WAIT_LO;
          tcnt <= '0;
        end
        REQ_HI: begin
          state <= WAIT_HI;
          tcnt <= '0;
        end
        WAIT_LO, WAIT_HI: begin
          // ack wins over a timeout expiring in the same cycle
          if (ack) begin
            if (state == WAIT_LO) begin
              lo <= count;
              state <= REQ_HI;
            end else begin
              value <= {count, lo};
              done <= 1'b1;
              state <= IDLE;
`ifdef ATOMIC_READER_DELTA_EN
              delta <= {count, lo} - value;
              first_n <= have_one;
              have_one <= 1'b1;
`endif
            end
          end else if (tcnt == LAST) begin
            state <= IDLE;
            timeout_err <= 1'b1;
          end else tcnt <= tcnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
